// File: rtl/alu_execute_unit_if.sv
// Handshake/operand bundle between the issue side, the execute ALU and the EX/MEM boundary.
interface alu_execute_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_ALUControl;
  logic [WIDTH-1:0] i_SrcA;
  logic [WIDTH-1:0] i_SrcB;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_ALUResult;
  logic             o_Zero;
  logic             o_IllegalOp;
  logic             o_busy;

  modport master (
    output i_valid, i_ALUControl, i_SrcA, i_SrcB, i_flush, i_ready,
    input  o_ready, o_valid, o_ALUResult, o_Zero, o_IllegalOp, o_busy
  );

  modport slave (
    input  i_valid, i_ALUControl, i_SrcA, i_SrcB, i_flush, i_ready,
    output o_ready, o_valid, o_ALUResult, o_Zero, o_IllegalOp, o_busy
  );
endinterface

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU with registered result and valid/ready handshake on both sides.
// Optional macro ALU_SERIAL_SHIFT_EN: SLL/SRL/SRA run 1 bit per cycle through a SHIFT state.
module alu_execute_unit #(
  parameter int WIDTH = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  alu_execute_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

`ifdef ALU_SERIAL_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

  state_t           state_r;
  logic             valid_r;
  logic             illegal_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH:0]   alu_out_s;
  logic             ready_s;
  logic             accept_s;
  logic             shift_run_s;

  // Returns {illegal, result}; undefined codes yield a zero result with the illegal bit set.
  function automatic logic [WIDTH:0] alu_calc(input logic [3:0] code,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [SHW-1:0] amt;
    logic [WIDTH:0] r;
    amt = b[SHW-1:0];
    case (code)
      OP_ADD:  r = {1'b0, a + b};
      OP_SUB:  r = {1'b0, a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SLT:  r = {1'b0, {(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {1'b0, {(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  r = {1'b0, a << amt};
      OP_SRL:  r = {1'b0, a >> amt};
      OP_SRA:  r = {1'b0, $unsigned($signed(a) >>> amt)};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  assign alu_out_s = alu_calc(bus.i_ALUControl, bus.i_SrcA, bus.i_SrcB);
  assign ready_s   = !i_reset && !shift_run_s && (!valid_r || bus.i_ready);
  assign accept_s  = bus.i_valid && ready_s && !bus.i_flush;

`ifdef ALU_SERIAL_SHIFT_EN
  logic             busy_r;
  logic [WIDTH-1:0] shreg_r;
  logic [SHW-1:0]   shcnt_r;
  logic [3:0]       shop_r;
  logic [WIDTH-1:0] shnext_s;
  logic             serial_start_s;

  // One-bit step of the serial shifter; anything not SLL/SRL is treated as SRA.
  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] code,
                                                  input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (code)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      default: r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign shnext_s       = shift_step(shop_r, shreg_r);
  assign serial_start_s = ((bus.i_ALUControl == OP_SLL) || (bus.i_ALUControl == OP_SRL) ||
                           (bus.i_ALUControl == OP_SRA)) && (bus.i_SrcB[SHW-1:0] != {SHW{1'b0}});
  assign shift_run_s    = (state_r == SHIFT);
  assign bus.o_busy     = busy_r;
`else
  assign shift_run_s    = 1'b0;
  assign bus.o_busy     = 1'b0;
`endif

  // Handshake FSM: flush beats accept and downstream ready; zero-amount shifts complete in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r   <= IDLE;
      valid_r   <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
      illegal_r <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      busy_r    <= 1'b0;
`endif
    end else if (bus.i_flush) begin
      state_r   <= IDLE;
      valid_r   <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      busy_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, HOLD: begin
          if (accept_s) begin
`ifdef ALU_SERIAL_SHIFT_EN
            if (serial_start_s) begin
              state_r <= SHIFT;
              valid_r <= 1'b0;
              busy_r  <= 1'b1;
              shreg_r <= bus.i_SrcA;
              shcnt_r <= bus.i_SrcB[SHW-1:0];
              shop_r  <= bus.i_ALUControl;
            end else begin
`endif
              state_r   <= HOLD;
              valid_r   <= 1'b1;
              result_r  <= alu_out_s[WIDTH-1:0];
              illegal_r <= alu_out_s[WIDTH];
`ifdef ALU_SERIAL_SHIFT_EN
            end
`endif
          end else if ((state_r == HOLD) && bus.i_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
`ifdef ALU_SERIAL_SHIFT_EN
        SHIFT: begin
          shreg_r <= shnext_s;
          shcnt_r <= shcnt_r - {{(SHW-1){1'b0}}, 1'b1};
          if (shcnt_r == {{(SHW-1){1'b0}}, 1'b1}) begin
            state_r   <= HOLD;
            valid_r   <= 1'b1;
            busy_r    <= 1'b0;
            result_r  <= shnext_s;
            illegal_r <= 1'b0;
          end else begin
            state_r <= SHIFT;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready     = ready_s;
  assign bus.o_valid     = valid_r;
  assign bus.o_ALUResult = result_r;
  assign bus.o_Zero      = (result_r == {WIDTH{1'b0}});
  assign bus.o_IllegalOp = illegal_r;
endmodule

// File: tb/tb_alu_execute_unit.sv
// Bench for alu_execute_unit: vector table through a scoreboard plus hand-written corner sequences.
module tb_alu_execute_unit;
`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_execute_unit_if #(.WIDTH(32)) bus ();
  alu_execute_unit #(.WIDTH(32)) dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
  } sb_t;

  int          total = 0;
  int          bad = 0;
  sb_t         q[$];
  logic [31:0] exp_res = 32'h0;
  logic        exp_ill = 1'b0;
  vec_t        vecs[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on downstream handshake, push on accept; flush/reset drop everything in flight.
  always @(negedge clk) begin
    if (rst || bus.i_flush) begin
      q.delete();
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          sb_t e;
          e = q.pop_front();
          chk("sb_result", bus.o_ALUResult, e.res);
          chk("sb_zero", bus.o_Zero, (e.res == 32'h0));
          chk("sb_illegal", bus.o_IllegalOp, e.ill);
        end
      end
      if (bus.i_valid && bus.o_ready) q.push_back({exp_res, exp_ill});
    end
  end

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic ill);
    bus.i_valid = 1'b1;
    bus.i_ALUControl = c;
    bus.i_SrcA = a;
    bus.i_SrcB = b;
    exp_res = r;
    exp_ill = ill;
  endtask

  task automatic wait_accept(output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.o_ready && !bus.i_flush;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic lat_seq(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input int lat);
    int n;
    bus.i_ready = 1'b1;
    set_op(c, a, b, r, 1'b0);
    wait_accept(n);
    bus.i_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk({nm, "_valid"}, bus.o_valid, (k == lat));
      chk({nm, "_busy"}, bus.o_busy, (k < lat));
      if (k < lat) begin
        chk({nm, "_ready"}, bus.o_ready, 64'd0);
        @(posedge clk);
        #1;
      end else begin
        chk({nm, "_result"}, bus.o_ALUResult, r);
        chk({nm, "_zero"}, bus.o_Zero, (r == 32'h0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  seen;
    vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[2]  = '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[3]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{4'h9, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0};
    vecs[5]  = '{4'hC, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    vecs[6]  = '{4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[7]  = '{4'h3, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0};
    vecs[8]  = '{4'h4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
    vecs[9]  = '{4'h6, 32'h00000001, 32'h00000005, 32'h00000020, 1'b0};
    vecs[10] = '{4'h7, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
    vecs[11] = '{4'h5, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    vecs[12] = '{4'h8, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[13] = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[14] = '{4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{4'h9, 32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF, 1'b0};
    vecs[16] = '{4'h6, 32'h00001234, 32'h00000020, 32'h00001234, 1'b0};
    vecs[17] = '{4'hA, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1};
    vecs[18] = '{4'h9, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0};

    bus.i_valid = 1'b0;
    bus.i_ALUControl = 4'h0;
    bus.i_SrcA = 32'h0;
    bus.i_SrcB = 32'h0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.o_ready, 64'd0);
    chk("rst_valid", bus.o_valid, 64'd0);
    chk("rst_result", bus.o_ALUResult, 64'd0);
    chk("rst_zero", bus.o_Zero, 64'd1);
    chk("rst_illegal", bus.o_IllegalOp, 64'd0);
    chk("rst_busy", bus.o_busy, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", bus.o_ready, 64'd1);
    @(posedge clk);
    #1;

    // Latency checks: single-cycle ops and shifts (serial shifts take amount+1 edges).
    lat_seq("add_ovf", 4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);
    lat_seq("sub_zero", 4'h1, 32'h5, 32'h5, 32'h0, 1);
    lat_seq("sll5", 4'h6, 32'h1, 32'h5, 32'h20, SERIAL ? 6 : 1);
    lat_seq("sll0", 4'h6, 32'h1234, 32'h0, 32'h1234, 1);
    lat_seq("sra1", 4'h9, 32'h80000000, 32'h21, 32'hC0000000, SERIAL ? 2 : 1);

    // Vector table, back-to-back with downstream always ready.
    bus.i_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      set_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill);
      wait_accept(n);
    end
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: first result held stable, second op taken when ready rises.
    bus.i_ready = 1'b0;
    set_op(4'h0, 32'h1, 32'h2, 32'h3, 1'b0);
    wait_accept(n);
    set_op(4'h4, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.o_valid, 64'd1);
      chk("bp_hold_result", bus.o_ALUResult, 64'h3);
      chk("bp_ready", bus.o_ready, 64'd0);
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_rise", bus.o_ready, 64'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", bus.o_valid, 64'd1);
    chk("bp_second_result", bus.o_ALUResult, 64'h0FF00FF0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_drained", bus.o_valid, 64'd0);
    @(posedge clk);
    #1;

    // Flush coincident with i_valid: the input is dropped.
    set_op(4'h0, 32'h9, 32'h9, 32'h12, 1'b0);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    chk("flush_in_dropped", seen, 64'd0);
    @(posedge clk);
    #1;

    // Flush while a result is held, with a new op offered and downstream ready.
    bus.i_ready = 1'b0;
    set_op(4'h0, 32'h1, 32'h1, 32'h2, 1'b0);
    wait_accept(n);
    set_op(4'h0, 32'h7, 32'h7, 32'hE, 1'b0);
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("flush_hold_valid", bus.o_valid, 64'd0);
    chk("flush_hold_busy", bus.o_busy, 64'd0);
    @(posedge clk);
    #1;

    // Flush mid-shift (serial build is still shifting; barrel build has already delivered).
    bus.i_ready = 1'b1;
    set_op(4'h6, 32'h3, 32'hA, 32'hC00, 1'b0);
    wait_accept(n);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    @(negedge clk);
    chk("flush_shift_valid", bus.o_valid, 64'd0);
    chk("flush_shift_busy", bus.o_busy, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    chk("flush_shift_never_valid", seen, 64'd0);
    @(posedge clk);
    #1;

    // Reset while a result is held, then accept on the first cycle after reset falls.
    bus.i_ready = 1'b0;
    set_op(4'h0, 32'h4, 32'h4, 32'h8, 1'b0);
    wait_accept(n);
    @(negedge clk);
    chk("mid_hold_valid", bus.o_valid, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_op(4'h0, 32'h1, 32'h1, 32'h2, 1'b0);
    @(negedge clk);
    chk("mid_rst_ready", bus.o_ready, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus.o_valid, 64'd0);
    chk("mid_rst_result", bus.o_ALUResult, 64'd0);
    chk("mid_rst_zero", bus.o_Zero, 64'd1);
    chk("mid_rst_illegal", bus.o_IllegalOp, 64'd0);
    chk("mid_rst_busy", bus.o_busy, 64'd0);
    chk("mid_rst_ready_after", bus.o_ready, 64'd1);
    bus.i_ready = 1'b1;
    set_op(4'h0, 32'h2, 32'h3, 32'h5, 1'b0);
    wait_accept(n);
    chk("post_rst_accept_cycles", n, 64'd1);
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.o_valid, 64'd1);
    chk("post_rst_result", bus.o_ALUResult, 64'h5);

    // Drain and confirm every accepted op came out exactly once.
    n = 0;
    while ((q.size() != 0 || bus.o_valid) && n < 100) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    chk("sb_drained", q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_execute_unit.md
# alu_execute_unit

Execute-stage ALU unit of the pipelined core. It consumes the 4-bit ALU control code produced by the ALU decoder together with two operands, performs the operation, and presents a registered result with a zero flag to the EX/MEM boundary. A valid/ready handshake on both sides lets the unit stall the pipeline when an operation takes more than one cycle (serial shifter) and lets downstream back-pressure it.

## Interface
- WIDTH, 32, operand/result width; power of two, minimum 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not to be overridden)

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  operation presented this cycle
- o_ready  output  1  unit accepts an operation this cycle
- i_ALUControl  input  4  operation code (ALU decoder encoding)
- i_SrcA  input  WIDTH  operand A
- i_SrcB  input  WIDTH  operand B / shift amount in [SHW-1:0]
- i_flush  input  1  discard in-flight and held operation
- o_valid  output  1  result held and valid
- i_ready  input  1  downstream takes result this cycle
- o_ALUResult  output  WIDTH  registered result
- o_Zero  output  1  o_ALUResult == 0 (combinational from result register)
- o_IllegalOp  output  1  registered; held op had an undefined code
- o_busy  output  1  multi-cycle shift in progress

## Operation
- Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SLTU, 1001 SRA. Codes 1010–1111: result 0, o_IllegalOp=1, completes as a single-cycle op.
- ADD/SUB modulo 2^WIDTH, no overflow output. SLT signed, SLTU unsigned; result 1 or 0, zero-extended.
- Shifts use i_SrcB[SHW-1:0] only; SRA fills with SrcA[WIDTH-1]; upper SrcB bits ignored.
- Accept = i_valid && o_ready && !i_flush.
- o_ready = !i_reset && state != SHIFT && (!o_valid || i_ready).
- States: IDLE (no result held), SHIFT (serial shift running, only with macro), HOLD (o_valid=1).
- IDLE/HOLD + accept of single-cycle op -> HOLD, result registered.
- HOLD + i_ready with no accept -> IDLE. HOLD + i_ready + accept -> HOLD with new result (back-to-back, no bubble).
- i_flush: next edge -> IDLE, o_valid=0, o_busy=0; flush beats accept and i_ready in the same cycle (input dropped).
- Reset: state IDLE, o_valid 0, o_ALUResult 0, o_Zero 1, o_IllegalOp 0, o_busy 0; o_ready 0 while i_reset is high, 1 after. Reset mid-shift abandons the shift.

## Timing
- Single-cycle ops: accept at edge E0; o_ALUResult and o_valid are visible in the cycle after E0 (latency 1).
- Throughput 1 op/cycle while downstream takes every result.
- Result, o_Zero and o_IllegalOp are stable while o_valid=1 && !i_ready.
- Serial shift with amount n>0: E0 loads operand and counter=n and enters SHIFT (o_busy=1, o_ready=0). Edges E1..En each shift 1 bit and decrement the counter. At En the unit enters HOLD, so o_valid is visible after En (latency n+1). Shift amount 0 behaves as a single-cycle op.

## Configuration
- ALU_SERIAL_SHIFT_EN defined: SLL/SRL/SRA run on the 1-bit-per-cycle FSM above, and SHIFT state exists.
- ALU_SERIAL_SHIFT_EN undefined: all shifts are single-cycle barrel shifts with latency 1, SHIFT state is absent, and o_busy is tied 0.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 -> after 1 cycle o_valid=1, result 0x80000000, o_Zero=0. SUB 5-5 -> 0, o_Zero=1.
- SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by SrcB=0x21 (amount 1) -> 0xC0000000. Code 1100 -> result 0, o_IllegalOp=1.
- Back-pressure: i_ready=0 for 3 cycles with 2 ops offered -> first result held stable, o_ready=0, second op accepted on the cycle i_ready rises, and no op is lost or duplicated.
- Serial shift build: SLL 1 by 5 -> o_busy=1 for 5 cycles, o_ready=0, result 0x20 valid 6 cycles after accept. Shift by 0 -> latency 1.
- i_flush during SHIFT, and i_flush coincident with i_valid -> next cycle o_valid=0, o_busy=0, flushed input never appears.
- Assert i_reset while o_valid=1 mid-stream -> next cycle all outputs at their reset values, and the unit accepts a new op the cycle after reset falls.
